// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared encodings for the sequential signed divider
// Holds the FSM state encoding and the ULA opcodes the decoder uses to
// form start (either opcode) and op_mod (ULA_MOD).
package div_seq_pkg;

   localparam logic [2:0] ULA_DIV = 3'd4;
   localparam logic [2:0] ULA_MOD = 3'd5;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_SIGN = 2'd2
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-subtract step
// Ports:
//   rem      partial remainder before the step
//   q        dividend/quotient shift register before the step
//   dvs      divisor magnitude
//   rem_next partial remainder after the step
//   q_next   quotient register after the step (new bit enters at lsb)
module div_step #(
   parameter int NBDATA = 32
) (
   input  logic [NBDATA-1:0] rem,
   input  logic [NBDATA-1:0] q,
   input  logic [NBDATA-1:0] dvs,
   output logic [NBDATA-1:0] rem_next,
   output logic [NBDATA-1:0] q_next
);

   // One extra bit so the shifted remainder can be compared against a
   // divisor magnitude of 2^(NBDATA-1) without overflow.
   logic [NBDATA:0] shifted;
   logic [NBDATA:0] diff;
   logic            ge;

   always_comb begin
      shifted  = {rem, q[NBDATA-1]};
      diff     = shifted - {1'b0, dvs};
      ge       = (shifted >= {1'b0, dvs});
      rem_next = NBDATA'(ge ? diff : shifted);
      q_next   = {q[NBDATA-2:0], ge};
   end

endmodule

// File: rtl/div_seq_fx.sv
// rtl/div_seq_fx.sv - multi-cycle signed divider for ULA DIV/MOD
// Ports:
//   clk, rst   clock; asynchronous active-high reset
//   start      request a division (sampled only in IDLE)
//   op_mod     0 = quotient, 1 = remainder (sampled with start)
//   dividend   signed accumulator operand (sampled with start)
//   divisor    signed memory/stack operand (sampled with start)
//   busy       registered, high while not in IDLE
//   stall      combinational pipeline freeze
//   done       registered one-cycle result-valid pulse
//   result     registered quotient or remainder, held until next done
//   dz         registered divide-by-zero flag, updated with done
module div_seq_fx
   import div_seq_pkg::*;
#(
   parameter int NBDATA = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              op_mod,
   input  logic [NBDATA-1:0] dividend,
   input  logic [NBDATA-1:0] divisor,
   output logic              busy,
   output logic              stall,
   output logic              done,
   output logic [NBDATA-1:0] result,
   output logic              dz
);

   localparam int CW = $clog2(NBDATA);
   localparam logic [CW-1:0] CNT_LAST = CW'(NBDATA - 1);
   localparam logic [NBDATA-1:0] Q_POS_SAT = {1'b0, {(NBDATA-1){1'b1}}};
   localparam logic [NBDATA-1:0] Q_NEG_SAT = {1'b1, {(NBDATA-1){1'b0}}};

   div_state_t        state, state_next;
   logic [CW-1:0]     cnt;
   logic [NBDATA-1:0] rem, q, dvs_abs;
   logic [NBDATA-1:0] rem_n, q_n;
   logic              sd, sv, mod_r, zero_r;
   logic              load, step, finish;
   logic [NBDATA-1:0] dvd_abs_in, dvs_abs_in;
   logic [NBDATA-1:0] q_signed, r_signed;

   assign stall = (start & ~busy) | busy;

   always_comb begin
      dvd_abs_in = dividend[NBDATA-1] ? -dividend : dividend;
      dvs_abs_in = divisor[NBDATA-1]  ? -divisor  : divisor;
   end

   div_step #(.NBDATA(NBDATA)) u_step (
      .rem      (rem),
      .q        (q),
      .dvs      (dvs_abs),
      .rem_next (rem_n),
      .q_next   (q_n)
   );

   // Sign fix-up. A zero divisor leaves q all ones, so the quotient is
   // replaced by the saturated value; the remainder path naturally ends up
   // holding |dividend|, which the sign fix-up turns back into dividend.
   always_comb begin
      q_signed = (sd ^ sv) ? -q : q;
      r_signed = sd ? -rem : rem;
      if (zero_r) begin
         q_signed = sd ? Q_NEG_SAT : Q_POS_SAT;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      finish     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               load       = 1'b1;
               state_next = S_CALC;
            end
         end
         S_CALC: begin
            step = 1'b1;
            if (cnt == CNT_LAST) begin
               state_next = S_SIGN;
            end
         end
         S_SIGN: begin
            finish     = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         dz      <= 1'b0;
         result  <= '0;
         cnt     <= '0;
         rem     <= '0;
         q       <= '0;
         dvs_abs <= '0;
         sd      <= 1'b0;
         sv      <= 1'b0;
         mod_r   <= 1'b0;
         zero_r  <= 1'b0;
      end else begin
         busy <= (state_next != S_IDLE);
         done <= 1'b0;
         if (load) begin
            q       <= dvd_abs_in;
            dvs_abs <= dvs_abs_in;
            sd      <= dividend[NBDATA-1];
            sv      <= divisor[NBDATA-1];
            mod_r   <= op_mod;
            zero_r  <= (divisor == '0);
            cnt     <= '0;
            rem     <= '0;
         end
         if (step) begin
            rem <= rem_n;
            q   <= q_n;
            cnt <= cnt + CW'(1);
         end
         if (finish) begin
            result <= mod_r ? r_signed : q_signed;
            dz     <= zero_r;
            done   <= 1'b1;
         end
      end
   end

endmodule
